proc_cmd_sequencer: RTL and testbench
=====================================

Name: proc_cmd_sequencer

Overview:
Sequences the arithmetic processor core on behalf of the host. Host writes to the command register are queued in a small FIFO and dispatched to the processor one at a time. Each dispatch latches the constant operands, pulses start, waits for done with a timeout, and captures the result. The block sits between the host interface register bank and the processor core, and exposes a 16-bit status word for host readback on HDO.

Parameters:
FIFO_DEPTH, 4, command queue depth; power of two, minimum 2.
TIMEOUT_CYCLES, 1000000, maximum WAIT cycles before abort; minimum 2.

Ports:
clk  input  1  system clock, 50 MHz
RESET  input  1  synchronous, active-high reset
cmd_wr  input  1  one-cycle pulse: host wrote the command register
cmd_in  input  4  command value written
constK  input  32  host constant K
const1  input  32  host constant 1
const2  input  32  host constant 2
const3  input  32  host constant 3
proc_done  input  1  processor completion pulse
proc_dout  input  32  processor result
proc_start  output  1  one-cycle start pulse to processor
proc_op  output  4  opcode presented to processor; stable from ISSUE to next ISSUE
proc_k  output  32  latched operand K
proc_c1  output  32  latched operand 1
proc_c2  output  32  latched operand 2
proc_c3  output  32  latched operand 3
result  output  32  last captured proc_dout
result_valid  output  1  result holds a completed op
busy  output  1  FSM not in IDLE, or FIFO non-empty
status  output  16  host readback word
perf_cycles  output  32  latency of last op (optional feature)

Behaviour:
- Reset: synchronous, highest priority. All outputs 0. FIFO empty. Sticky flags clear. FSM in IDLE. Applies mid-operation: an in-flight op is abandoned with no capture.
- Command decode on cmd_wr:
  - 4'h0 = NOP: ignored.
  - 4'hF = CLEAR: not queued. Flushes the FIFO, clears the sticky flags and result_valid. Forces FSM to IDLE from any state; proc_start is not issued that cycle.
  - Any other value: pushed to the FIFO.
- Push while FIFO full, judged at the sampling edge: command dropped, ovf flag set. A simultaneous pop does not free space for it.
- FSM:
  - IDLE: if the FIFO is non-empty, pop the head into proc_op, latch constK/1/2/3 into proc_k/c1/c2/c3, go to ISSUE.
  - ISSUE: proc_start=1 for exactly this one cycle. Clear result_valid. Clear the timeout counter. Go to WAIT.
  - WAIT: increment the counter each cycle.
    - proc_done=1: result<=proc_dout, result_valid<=1, last_op<=proc_op, go to IDLE.
    - Counter reaches TIMEOUT_CYCLES first: set tmo flag, result unchanged, go to IDLE.
    - proc_done sampled only in WAIT; ignored elsewhere.
- Latency: cmd_wr sampled at edge E0 with FIFO empty and FSM in IDLE. proc_start is high in the cycle after edge E1. After done, the next queued op's proc_start is high 2 cycles after the done cycle.
- Constants are sampled at dispatch, not at enqueue. The host must not change constants while busy if it needs per-command operands.
- status: [3:0] last_op; [6:4] FIFO count (saturating at 7); [7] busy; [8] result_valid; [9] ovf; [10] tmo; [15:11] 0.
- Simultaneous CLEAR and proc_done: CLEAR wins; no capture.

Optional Feature:
PROC_SEQ_PERF_EN
- Defined: a 32-bit counter runs from ISSUE (value 1) through WAIT. On completion or timeout, perf_cycles loads the count. Reset and CLEAR zero it.
- Undefined: perf_cycles is tied to 0 and no counter logic is built.

Test Plan:
- Single op: constK=0x12345678, cmd 4'h3; processor returns done 5 cycles after start with dout 0xCAFEBABE -> proc_start high 2 cycles after cmd_wr; proc_k=0x12345678, proc_op=3; result=0xCAFEBABE, result_valid=1, status=0x0103; perf_cycles=6 if enabled.
- Queue/overflow: 6 back-to-back writes 1..6 while the processor stalls -> at most 4 queued (ops 2..5 after op 1 dispatches), op 6 dropped, status[9]=1; ops execute in order 1,2,3,4,5.
- Timeout: TIMEOUT_CYCLES=10, proc_done never asserted -> FSM returns to IDLE after 10 WAIT cycles, status[10]=1, result_valid=0, the next queued op dispatches.
- CLEAR mid-op: 3 queued, CLEAR written during WAIT -> FIFO count 0, busy=0 next cycle, flags cleared; a later proc_done is ignored.
- Reset mid-op: RESET high for 1 cycle during WAIT -> all outputs 0 on the following cycle, no proc_start until a new command.
- NOP and done-outside-WAIT: cmd 4'h0 -> nothing queued; proc_done pulse while IDLE -> result unchanged.

Source files
------------

// File: rtl/proc_cmd_sequencer.sv
// Queues host commands and dispatches them one at a time to the arithmetic processor core.
// Define PROC_SEQ_PERF_EN to build the per-op latency counter that drives perf_cycles.
module proc_cmd_sequencer #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic        cmd_wr,
    input  logic [3:0]  cmd_in,
    input  logic [31:0] constK,
    input  logic [31:0] const1,
    input  logic [31:0] const2,
    input  logic [31:0] const3,
    input  logic        proc_done,
    input  logic [31:0] proc_dout,
    output logic        proc_start,
    output logic [3:0]  proc_op,
    output logic [31:0] proc_k,
    output logic [31:0] proc_c1,
    output logic [31:0] proc_c2,
    output logic [31:0] proc_c3,
    output logic [31:0] result,
    output logic        result_valid,
    output logic        busy,
    output logic [15:0] status,
    output logic [31:0] perf_cycles
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [3:0] CmdNop   = 4'h0;
    localparam logic [3:0] CmdClear = 4'hF;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    fifo_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

    logic [3:0]    op_q, op_d;
    logic [31:0]   k_q, k_d;
    logic [31:0]   c1_q, c1_d;
    logic [31:0]   c2_q, c2_d;
    logic [31:0]   c3_q, c3_d;
    logic [31:0]   result_q, result_d;
    logic          rv_q, rv_d;
    logic [3:0]    last_op_q, last_op_d;
    logic          ovf_q, ovf_d;
    logic          tmo_q, tmo_d;

    logic          clear;
    logic          push_req;
    logic          full;
    logic          push;
    logic          pop;
    logic          start;
    logic [2:0]    cnt_sat;

    assign clear    = cmd_wr && (cmd_in == CmdClear);
    assign push_req = cmd_wr && (cmd_in != CmdNop) && (cmd_in != CmdClear);
    assign full     = (count_q == CW'(FIFO_DEPTH));

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        tmo_cnt_d = tmo_cnt_q;
        op_d      = op_q;
        k_d       = k_q;
        c1_d      = c1_q;
        c2_d      = c2_q;
        c3_d      = c3_q;
        result_d  = result_q;
        rv_d      = rv_q;
        last_op_d = last_op_q;
        ovf_d     = ovf_q;
        tmo_d     = tmo_q;
        push      = 1'b0;
        pop       = 1'b0;
        start     = 1'b0;

        if (clear) begin
            // CLEAR beats everything, including a done arriving in the same cycle.
            state_d  = StIdle;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            rv_d     = 1'b0;
            ovf_d    = 1'b0;
            tmo_d    = 1'b0;
        end else begin
            // Fullness is judged on the registered count, so a same-cycle pop never makes room.
            push = push_req && !full;
            if (push_req && full) begin
                ovf_d = 1'b1;
            end

            case (state_q)
                StIdle: begin
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        op_d    = fifo_q[rd_ptr_q];
                        k_d     = constK;
                        c1_d    = const1;
                        c2_d    = const2;
                        c3_d    = const3;
                        state_d = StIssue;
                    end
                end
                StIssue: begin
                    start     = 1'b1;
                    rv_d      = 1'b0;
                    tmo_cnt_d = '0;
                    state_d   = StWait;
                end
                StWait: begin
                    if (proc_done) begin
                        result_d  = proc_dout;
                        rv_d      = 1'b1;
                        last_op_d = op_q;
                        state_d   = StIdle;
                    end else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        tmo_d   = 1'b1;
                        state_d = StIdle;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + TW'(1);
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase

            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q   <= StIdle;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            tmo_cnt_q <= '0;
            op_q      <= '0;
            k_q       <= '0;
            c1_q      <= '0;
            c2_q      <= '0;
            c3_q      <= '0;
            result_q  <= '0;
            rv_q      <= 1'b0;
            last_op_q <= '0;
            ovf_q     <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            tmo_cnt_q <= tmo_cnt_d;
            op_q      <= op_d;
            k_q       <= k_d;
            c1_q      <= c1_d;
            c2_q      <= c2_d;
            c3_q      <= c3_d;
            result_q  <= result_d;
            rv_q      <= rv_d;
            last_op_q <= last_op_d;
            ovf_q     <= ovf_d;
            tmo_q     <= tmo_d;
        end
    end

    // Storage needs no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (!RESET && push) begin
            fifo_q[wr_ptr_q] <= cmd_in;
        end
    end

`ifdef PROC_SEQ_PERF_EN
    logic [31:0] perf_cnt_q, perf_cnt_d;
    logic [31:0] perf_cycles_q, perf_cycles_d;

    always_comb begin
        perf_cnt_d    = perf_cnt_q;
        perf_cycles_d = perf_cycles_q;
        if (clear) begin
            perf_cnt_d    = '0;
            perf_cycles_d = '0;
        end else begin
            // Count is 1 during ISSUE and keeps climbing through WAIT.
            if (pop) begin
                perf_cnt_d = 32'd1;
            end else if (state_q == StIssue || state_q == StWait) begin
                perf_cnt_d = perf_cnt_q + 32'd1;
            end
            if (state_q == StWait && state_d == StIdle) begin
                perf_cycles_d = perf_cnt_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            perf_cnt_q    <= '0;
            perf_cycles_q <= '0;
        end else begin
            perf_cnt_q    <= perf_cnt_d;
            perf_cycles_q <= perf_cycles_d;
        end
    end

    assign perf_cycles = perf_cycles_q;
`else
    assign perf_cycles = '0;
`endif

    assign cnt_sat = (32'(count_q) > 32'd7) ? 3'd7 : 3'(count_q);

    assign proc_start   = start;
    assign proc_op      = op_q;
    assign proc_k       = k_q;
    assign proc_c1      = c1_q;
    assign proc_c2      = c2_q;
    assign proc_c3      = c3_q;
    assign result       = result_q;
    assign result_valid = rv_q;
    assign busy         = (state_q != StIdle) || (count_q != '0);
    assign status       = {5'b0, tmo_q, ovf_q, rv_q, busy, cnt_sat, last_op_q};

endmodule

// File: tb/tb_proc_cmd_sequencer.sv
// Directed bench for proc_cmd_sequencer: single op, queue/overflow, timeout, CLEAR, reset, NOP.
module tb_proc_cmd_sequencer;

    logic        clk;
    logic        RESET;
    logic        cmd_wr;
    logic [3:0]  cmd_in;
    logic [31:0] constK, const1, const2, const3;
    logic        proc_done;
    logic [31:0] proc_dout;
    logic        proc_start;
    logic [3:0]  proc_op;
    logic [31:0] proc_k, proc_c1, proc_c2, proc_c3;
    logic [31:0] result;
    logic        result_valid;
    logic        busy;
    logic [15:0] status;
    logic [31:0] perf_cycles;

    int n_total = 0;
    int n_bad   = 0;

    localparam logic [31:0] Base = 32'h1000_0000;

    proc_cmd_sequencer #(
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .clk          (clk),
        .RESET        (RESET),
        .cmd_wr       (cmd_wr),
        .cmd_in       (cmd_in),
        .constK       (constK),
        .const1       (const1),
        .const2       (const2),
        .const3       (const3),
        .proc_done    (proc_done),
        .proc_dout    (proc_dout),
        .proc_start   (proc_start),
        .proc_op      (proc_op),
        .proc_k       (proc_k),
        .proc_c1      (proc_c1),
        .proc_c2      (proc_c2),
        .proc_c3      (proc_c3),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .status       (status),
        .perf_cycles  (perf_cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_perf;
`ifdef PROC_SEQ_PERF_EN
        exp_perf = 32'd6;
`else
        exp_perf = 32'd0;
`endif
        RESET = 1'b1; cmd_wr = 1'b0; cmd_in = 4'h0;
        constK = '0; const1 = '0; const2 = '0; const3 = '0;
        proc_done = 1'b0; proc_dout = '0;
        step();
        step();
        RESET = 1'b0;
        step();

        // Reset state
        check_eq("rst_status", 32'(status), 32'h0000);
        check_eq("rst_start", 32'(proc_start), 32'd0);
        check_eq("rst_result", result, 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_perf", perf_cycles, 32'd0);

        // Single op
        constK = 32'h1234_5678; const1 = 32'h1; const2 = 32'h2; const3 = 32'h3;
        cmd_wr = 1'b1; cmd_in = 4'h3;
        step();
        cmd_wr = 1'b0;
        check_eq("single_queued_status", 32'(status), 32'h0090);
        check_eq("single_no_early_start", 32'(proc_start), 32'd0);
        step();
        check_eq("single_start", 32'(proc_start), 32'd1);
        check_eq("single_op", 32'(proc_op), 32'd3);
        check_eq("single_k", proc_k, 32'h1234_5678);
        check_eq("single_c3", proc_c3, 32'h3);
        step();
        constK = 32'h0BAD_F00D;
        check_eq("single_start_one_cycle", 32'(proc_start), 32'd0);
        step();
        step();
        step();
        step();
        check_eq("single_k_latched", proc_k, 32'h1234_5678);
        proc_done = 1'b1; proc_dout = 32'hCAFE_BABE;
        step();
        proc_done = 1'b0;
        check_eq("single_result", result, 32'hCAFE_BABE);
        check_eq("single_rv", 32'(result_valid), 32'd1);
        check_eq("single_status", 32'(status), 32'h0103);
        check_eq("single_perf", perf_cycles, exp_perf);

        // NOP and done outside WAIT
        cmd_wr = 1'b1; cmd_in = 4'h0; proc_done = 1'b1; proc_dout = 32'hDEAD_BEEF;
        step();
        cmd_wr = 1'b0; proc_done = 1'b0;
        check_eq("nop_status", 32'(status), 32'h0103);
        check_eq("idle_done_result", result, 32'hCAFE_BABE);
        step();
        check_eq("nop_no_start", 32'(proc_start), 32'd0);

        // Queue and overflow: six back-to-back writes
        for (int i = 1; i <= 6; i++) begin
            if (i == 3) begin
                check_eq("q_start1", 32'(proc_start), 32'd1);
                check_eq("q_op1", 32'(proc_op), 32'd1);
                check_eq("q_k_dispatch", proc_k, 32'h0BAD_F00D);
            end
            cmd_wr = 1'b1; cmd_in = 4'(i);
            step();
        end
        cmd_wr = 1'b0;
        check_eq("q_status_full_ovf", 32'(status), 32'h02C3);
        proc_done = 1'b1; proc_dout = Base + 32'd1;
        step();
        proc_done = 1'b0;
        check_eq("q_result1", result, Base + 32'd1);
        for (int j = 2; j <= 5; j++) begin
            check_eq("q_gap_no_start", 32'(proc_start), 32'd0);
            step();
            check_eq("q_start_2_after_done", 32'(proc_start), 32'd1);
            check_eq("q_op_order", 32'(proc_op), 32'(j));
            step();
            proc_done = 1'b1; proc_dout = Base + 32'(j);
            step();
            proc_done = 1'b0;
            check_eq("q_result", result, Base + 32'(j));
        end
        check_eq("q_final_status", 32'(status), 32'h0305);

        // Timeout with a second op queued behind
        cmd_wr = 1'b1; cmd_in = 4'h7;
        step();
        cmd_in = 4'h8;
        step();
        cmd_wr = 1'b0;
        check_eq("tmo_start7", 32'(proc_start), 32'd1);
        check_eq("tmo_op7", 32'(proc_op), 32'd7);
        for (int i = 0; i < 10; i++) begin
            step();
        end
        check_eq("tmo_last_wait_status", 32'(status), 32'h0295);
        step();
        check_eq("tmo_status", 32'(status), 32'h0695);
        check_eq("tmo_result_kept", result, Base + 32'd5);
        check_eq("tmo_rv", 32'(result_valid), 32'd0);
        step();
        check_eq("tmo_next_start", 32'(proc_start), 32'd1);
        check_eq("tmo_next_op", 32'(proc_op), 32'd8);

        // CLEAR during WAIT with three queued
        for (int i = 9; i <= 11; i++) begin
            cmd_wr = 1'b1; cmd_in = 4'(i);
            step();
        end
        cmd_wr = 1'b0;
        check_eq("clr_pre_status", 32'(status), 32'h06B5);
        cmd_wr = 1'b1; cmd_in = 4'hF;
        step();
        cmd_wr = 1'b0;
        check_eq("clr_status", 32'(status), 32'h0005);
        check_eq("clr_busy", 32'(busy), 32'd0);
        proc_done = 1'b1; proc_dout = 32'h0000_0BAD;
        step();
        proc_done = 1'b0;
        check_eq("clr_late_done_ignored", result, Base + 32'd5);
        check_eq("clr_late_done_rv", 32'(result_valid), 32'd0);
        step();
        check_eq("clr_no_start", 32'(proc_start), 32'd0);

        // CLEAR coinciding with done
        cmd_wr = 1'b1; cmd_in = 4'hC;
        step();
        cmd_wr = 1'b0;
        step();
        check_eq("clrdone_start", 32'(proc_start), 32'd1);
        check_eq("clrdone_op", 32'(proc_op), 32'd12);
        step();
        cmd_wr = 1'b1; cmd_in = 4'hF; proc_done = 1'b1; proc_dout = 32'h0000_BAD2;
        step();
        cmd_wr = 1'b0; proc_done = 1'b0;
        check_eq("clrdone_result", result, Base + 32'd5);
        check_eq("clrdone_status", 32'(status), 32'h0005);

        // Reset during WAIT
        cmd_wr = 1'b1; cmd_in = 4'h6;
        step();
        cmd_in = 4'h7;
        step();
        cmd_wr = 1'b0;
        check_eq("rstmid_start", 32'(proc_start), 32'd1);
        step();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        check_eq("rstmid_status", 32'(status), 32'h0000);
        check_eq("rstmid_result", result, 32'd0);
        check_eq("rstmid_op", 32'(proc_op), 32'd0);
        check_eq("rstmid_k", proc_k, 32'd0);
        check_eq("rstmid_c1", proc_c1, 32'd0);
        check_eq("rstmid_perf", perf_cycles, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check_eq("rstmid_no_start", 32'(proc_start), 32'd0);
            step();
        end

        // Fresh command after reset
        cmd_wr = 1'b1; cmd_in = 4'h2;
        step();
        cmd_wr = 1'b0;
        step();
        check_eq("post_rst_start", 32'(proc_start), 32'd1);
        check_eq("post_rst_op", 32'(proc_op), 32'd2);
        check_eq("post_rst_k", proc_k, 32'h0BAD_F00D);
        check_eq("post_rst_c2", proc_c2, 32'h2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
